// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr} entries with flush.
// Define IF_ID_QUEUE_BYPASS_EN to let an empty queue forward the fetch entry to decode combinationally.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      i_if_instr,
    input  logic [63:0]      i_if_pc,
    input  logic             i_if_valid_instr,
    output logic             o_if_ready,
    input  logic             i_flush,
    input  logic             i_id_ready,
    output logic [31:0]      o_id_instr,
    output logic [63:0]      o_id_pc,
    output logic             o_id_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 96;
`ifdef IF_ID_QUEUE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, bypass, st_push, st_pop;
    logic [ENT_W-1:0] head;

    always_comb begin
        o_full     = (count_q == CNT_W'(DEPTH));
        o_empty    = (count_q == '0);
        o_count    = count_q;
        // Ready depends on registered state only, so a pop while full cannot admit a push.
        o_if_ready = ~o_full;

        bypass     = BYPASS_EN & o_empty & i_if_valid_instr & ~i_flush;
        o_id_valid = (~o_empty & ~i_flush) | bypass;
        head       = bypass ? {i_if_pc, i_if_instr} : mem_q[rd_ptr_q];
        o_id_instr = o_id_valid ? head[31:0]  : '0;
        o_id_pc    = o_id_valid ? head[95:32] : '0;

        push    = i_if_valid_instr & o_if_ready & ~i_flush;
        pop     = o_id_valid & i_id_ready;
        // A bypassed entry consumed in the same cycle never touches storage.
        st_push = push & ~(bypass & i_id_ready);
        st_pop  = pop & ~bypass;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (st_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (st_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({st_push, st_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; output muxes hide stale contents.
    always_ff @(posedge clk) begin
        if (st_push) mem_q[wr_ptr_q] <= {i_if_pc, i_if_instr};
    end

endmodule
